// File: rtl/e800j_restart_ctrl.sv
// Control register and restart sequencer for the Elwro 800 Junior memory map.
// Drives the BOOT/f7_q1/RELOK map modes and holds the CPU in reset after power-up or RESTART.
module e800j_restart_ctrl #(
    parameter int          RST_CYCLES      = 16,
    parameter int          DEBOUNCE_CYCLES = 1024,
    parameter logic [7:0]  PORT_ADDR       = 8'hF7
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic [7:0] A,
    input  logic [7:0] D,
    input  logic       nIORQ,
    input  logic       nWR,
    input  logic       nM1,
    input  logic       nIAH,
    input  logic       nRESTART,
    output logic       BOOT,
    output logic       f7_q1,
    output logic       RELOK,
    output logic       nCPU_RST,
    output logic       IAH_ACK
);

    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DB_SAT    = DW'(DEBOUNCE_CYCLES);

    localparam logic [1:0] HOLD     = 2'd0;
    localparam logic [1:0] RUN      = 2'd1;
    localparam logic [1:0] IAH_WAIT = 2'd2;

    logic [4:0]    syncMeta;
    logic [4:0]    syncOut;
    logic          nIorqS;
    logic          nWrS;
    logic          nM1S;
    logic          nIahS;
    logic          nRestartS;

    logic [1:0]    state;
    logic [HW-1:0] holdCnt;
    logic [DW-1:0] dbCnt;
    logic          wrAct;
    logic          wrActD;
    logic          commit;
    logic          restartTrig;
    logic          iahDone;
    logic          bootQ;
    logic          f7Q;
    logic          relokQ;
    logic          nCpuRstQ;
    logic          iahAckQ;
    logic          unusedD;

    // Bus strobes and the RESTART key are asynchronous; idle level is high.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            syncMeta <= '1;
            syncOut  <= '1;
        end else begin
            syncMeta <= {nIORQ, nWR, nM1, nIAH, nRESTART};
            syncOut  <= syncMeta;
        end
    end

    assign nIorqS    = syncOut[4];
    assign nWrS      = syncOut[3];
    assign nM1S      = syncOut[2];
    assign nIahS     = syncOut[1];
    assign nRestartS = syncOut[0];

    // A and D are already stable by the time the synchronised strobe is seen.
    assign wrAct   = ~nIorqS & ~nWrS & (A == PORT_ADDR);
    assign commit  = wrAct & ~wrActD & (state != HOLD);
    assign iahDone = (state == IAH_WAIT) & nM1S;
    assign unusedD = ^D[7:3];

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wrActD <= 1'b0;
        end else begin
            wrActD <= wrAct;
        end
    end

    // Counter stops one past the trigger value so a held key fires only once.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            dbCnt <= '0;
        end else if (nRestartS) begin
            dbCnt <= '0;
        end else if (dbCnt != DB_SAT) begin
            dbCnt <= dbCnt + DW'(1);
        end
    end

    assign restartTrig = ~nRestartS & (dbCnt == DB_LAST);

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state    <= HOLD;
            holdCnt  <= '0;
            bootQ    <= 1'b1;
            f7Q      <= 1'b0;
            relokQ   <= 1'b0;
            nCpuRstQ <= 1'b0;
            iahAckQ  <= 1'b0;
        end else begin
            iahAckQ <= 1'b0;
            if (restartTrig) begin
                state    <= HOLD;
                holdCnt  <= '0;
                bootQ    <= 1'b1;
                f7Q      <= 1'b0;
                relokQ   <= 1'b0;
                nCpuRstQ <= 1'b0;
            end else begin
                case (state)
                    HOLD: begin
                        if (holdCnt == HOLD_LAST) begin
                            state    <= RUN;
                            holdCnt  <= '0;
                            nCpuRstQ <= 1'b1;
                        end else begin
                            holdCnt <= holdCnt + HW'(1);
                        end
                    end
                    RUN: begin
                        if (~nIahS & ~nM1S) begin
                            state <= IAH_WAIT;
                        end
                    end
                    IAH_WAIT: begin
                        if (nM1S) begin
                            state   <= RUN;
                            iahAckQ <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= HOLD;
                        holdCnt  <= '0;
                        nCpuRstQ <= 1'b0;
                    end
                endcase

                // The IAH clear beats the write's mode bits, but a BOOT clear still lands.
                if (commit && D[2]) begin
                    bootQ <= 1'b0;
                end
                if (iahDone) begin
                    f7Q    <= 1'b0;
                    relokQ <= 1'b0;
                end else if (commit) begin
                    f7Q    <= D[0];
                    relokQ <= D[1];
                end
            end
        end
    end

    assign BOOT     = bootQ;
    assign f7_q1    = f7Q;
    assign RELOK    = relokQ;
    assign nCPU_RST = nCpuRstQ;
    assign IAH_ACK  = iahAckQ;

endmodule

// File: tb/tb_e800j_restart_ctrl.sv
// Self-checking bench for e800j_restart_ctrl with a transaction-level expectation model.
module tb_e800j_restart_ctrl;

    localparam int RST_C = 16;
    localparam int DB_C  = 8;

    logic       CLK = 1'b0;
    logic       nRESET = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] D = 8'h00;
    logic       nIORQ = 1'b1;
    logic       nWR = 1'b1;
    logic       nM1 = 1'b1;
    logic       nIAH = 1'b1;
    logic       nRESTART = 1'b1;
    logic       BOOT;
    logic       f7_q1;
    logic       RELOK;
    logic       nCPU_RST;
    logic       IAH_ACK;

    int errors = 0;
    int checks = 0;

    // Expected map mode, updated from whole transactions.
    logic expBoot  = 1'b1;
    logic expF7    = 1'b0;
    logic expRelok = 1'b0;

    always #5 CLK = ~CLK;

    e800j_restart_ctrl #(
        .RST_CYCLES(RST_C),
        .DEBOUNCE_CYCLES(DB_C),
        .PORT_ADDR(8'hF7)
    ) dut (
        .CLK(CLK),
        .nRESET(nRESET),
        .A(A),
        .D(D),
        .nIORQ(nIORQ),
        .nWR(nWR),
        .nM1(nM1),
        .nIAH(nIAH),
        .nRESTART(nRESTART),
        .BOOT(BOOT),
        .f7_q1(f7_q1),
        .RELOK(RELOK),
        .nCPU_RST(nCPU_RST),
        .IAH_ACK(IAH_ACK)
    );

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Stimulus only: a complete OUT cycle followed by settling time.
    task automatic driveWrite(input logic [7:0] addr, input logic [7:0] data, input int hold);
        A = addr; D = data; nIORQ = 1'b0; nWR = 1'b0;
        step(hold);
        nIORQ = 1'b1; nWR = 1'b1;
        step(3);
    endtask

    task automatic applyWriteModel(input logic [7:0] addr, input logic [7:0] data);
        if (addr == 8'hF7) begin
            expF7 = data[0];
            expRelok = data[1];
            if (data[2]) expBoot = 1'b0;
        end
    endtask

    task automatic test_reset();
        int n;
        nRESET = 1'b0;
        step(3);
        checks++;
        if ({BOOT, f7_q1, RELOK, nCPU_RST, IAH_ACK} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_values: got %b expected 10000", {BOOT, f7_q1, RELOK, nCPU_RST, IAH_ACK});
        end
        nRESET = 1'b1;
        n = 0;
        while (nCPU_RST !== 1'b1 && n < 100) begin
            step(1);
            n++;
        end
        checks++;
        if (n !== RST_C) begin
            errors++;
            $display("FAIL reset_hold_len: got %0d edges expected %0d", n, RST_C);
        end
        expBoot = 1'b1; expF7 = 1'b0; expRelok = 1'b0;
        checks++;
        if ({BOOT, f7_q1, RELOK} !== {expBoot, expF7, expRelok}) begin
            errors++;
            $display("FAIL reset_run_regs: got %b expected %b", {BOOT, f7_q1, RELOK}, {expBoot, expF7, expRelok});
        end
    endtask

    task automatic test_port_write();
        logic [7:0] addr;
        logic [7:0] data;
        int hold;
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                addr = 8'hF7; data = 8'h07; hold = 10;
            end else begin
                data = 8'($urandom);
                hold = $urandom_range(3, 10);
                addr = (k == 1 || $urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 8'hF6)) : 8'hF7;
            end
            A = addr; D = data; nIORQ = 1'b0; nWR = 1'b0;
            step(2);
            checks++;
            if ({BOOT, f7_q1, RELOK} !== {expBoot, expF7, expRelok}) begin
                errors++;
                $display("FAIL wr_early k=%0d: got %b expected %b", k, {BOOT, f7_q1, RELOK}, {expBoot, expF7, expRelok});
            end
            step(1);
            applyWriteModel(addr, data);
            checks++;
            if ({BOOT, f7_q1, RELOK} !== {expBoot, expF7, expRelok}) begin
                errors++;
                $display("FAIL wr_commit k=%0d a=%h d=%h: got %b expected %b", k, addr, data, {BOOT, f7_q1, RELOK}, {expBoot, expF7, expRelok});
            end
            // Changing D while the strobe is still held must not be taken up.
            D = ~data;
            step(hold - 3 + 1);
            nIORQ = 1'b1; nWR = 1'b1;
            step(3);
            checks++;
            if ({BOOT, f7_q1, RELOK} !== {expBoot, expF7, expRelok}) begin
                errors++;
                $display("FAIL wr_once k=%0d: got %b expected %b", k, {BOOT, f7_q1, RELOK}, {expBoot, expF7, expRelok});
            end
        end
    endtask

    task automatic test_iah();
        logic [7:0] data;
        for (int k = 0; k < 3; k++) begin
            data = {6'b0, 2'($urandom_range(1, 3))};
            driveWrite(8'hF7, data, 4);
            applyWriteModel(8'hF7, data);
            nM1 = 1'b0; nIAH = 1'b0;
            step(3);
            nM1 = 1'b1; nIAH = 1'b1;
            step(2);
            checks++;
            if ({IAH_ACK, BOOT, f7_q1, RELOK} !== {1'b0, expBoot, expF7, expRelok}) begin
                errors++;
                $display("FAIL iah_early k=%0d: got %b expected %b", k, {IAH_ACK, BOOT, f7_q1, RELOK}, {1'b0, expBoot, expF7, expRelok});
            end
            step(1);
            expF7 = 1'b0; expRelok = 1'b0;
            checks++;
            if ({IAH_ACK, BOOT, f7_q1, RELOK} !== {1'b1, expBoot, expF7, expRelok}) begin
                errors++;
                $display("FAIL iah_ack k=%0d: got %b expected %b", k, {IAH_ACK, BOOT, f7_q1, RELOK}, {1'b1, expBoot, expF7, expRelok});
            end
            step(1);
            checks++;
            if (IAH_ACK !== 1'b0) begin
                errors++;
                $display("FAIL iah_pulse_width k=%0d: got %b expected 0", k, IAH_ACK);
            end
        end
    endtask

    task automatic test_restart_glitch();
        logic sawLow;
        driveWrite(8'hF7, 8'h07, 4);
        applyWriteModel(8'hF7, 8'h07);
        sawLow = 1'b0;
        nRESTART = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (nCPU_RST !== 1'b1) sawLow = 1'b1;
        end
        nRESTART = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (nCPU_RST !== 1'b1) sawLow = 1'b1;
        end
        checks++;
        if (sawLow !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reset: got nCPU_RST low expected high throughout");
        end
        checks++;
        if ({BOOT, f7_q1, RELOK} !== {expBoot, expF7, expRelok}) begin
            errors++;
            $display("FAIL glitch_regs: got %b expected %b", {BOOT, f7_q1, RELOK}, {expBoot, expF7, expRelok});
        end
    endtask

    task automatic test_restart();
        int n;
        int m;
        logic sawLow;
        logic [7:0] data;
        data = {5'b0, 3'($urandom_range(1, 7))};
        driveWrite(8'hF7, data, 4);
        applyWriteModel(8'hF7, data);
        nRESTART = 1'b0;
        n = 0;
        while (nCPU_RST !== 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        checks++;
        if (n !== DB_C + 2) begin
            errors++;
            $display("FAIL restart_latency: got %0d edges expected %0d", n, DB_C + 2);
        end
        expBoot = 1'b1; expF7 = 1'b0; expRelok = 1'b0;
        checks++;
        if ({BOOT, f7_q1, RELOK} !== {expBoot, expF7, expRelok}) begin
            errors++;
            $display("FAIL restart_regs: got %b expected %b", {BOOT, f7_q1, RELOK}, {expBoot, expF7, expRelok});
        end
        m = 0;
        while (nCPU_RST !== 1'b1 && m < 100) begin
            step(1);
            m++;
        end
        checks++;
        if (m !== RST_C) begin
            errors++;
            $display("FAIL restart_hold_len: got %0d edges expected %0d", m, RST_C);
        end
        sawLow = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (nCPU_RST !== 1'b1) sawLow = 1'b1;
        end
        checks++;
        if (sawLow !== 1'b0) begin
            errors++;
            $display("FAIL restart_refire_held: got a second restart expected none");
        end

        // Release, press again; then write BOOT-clear during HOLD.
        nRESTART = 1'b1;
        step(4);
        nRESTART = 1'b0;
        n = 0;
        while (nCPU_RST !== 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        checks++;
        if (n !== DB_C + 2) begin
            errors++;
            $display("FAIL restart_second: got %0d edges expected %0d", n, DB_C + 2);
        end
        A = 8'hF7; D = 8'h04; nIORQ = 1'b0; nWR = 1'b0;
        step(4);
        nIORQ = 1'b1; nWR = 1'b1;
        m = 4;
        while (nCPU_RST !== 1'b1 && m < 100) begin
            step(1);
            m++;
        end
        checks++;
        if (m !== RST_C) begin
            errors++;
            $display("FAIL restart_hold_len2: got %0d edges expected %0d", m, RST_C);
        end
        step(2);
        checks++;
        if ({BOOT, f7_q1, RELOK} !== {expBoot, expF7, expRelok}) begin
            errors++;
            $display("FAIL hold_write_ignored: got %b expected %b", {BOOT, f7_q1, RELOK}, {expBoot, expF7, expRelok});
        end

        // A strobe that starts in HOLD and is still held into RUN.
        nRESTART = 1'b1;
        step(4);
        nRESTART = 1'b0;
        n = 0;
        while (nCPU_RST !== 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        A = 8'hF7; D = 8'h07; nIORQ = 1'b0; nWR = 1'b0;
        step(25);
        nIORQ = 1'b1; nWR = 1'b1;
        step(3);
        checks++;
        if ({nCPU_RST, BOOT, f7_q1, RELOK} !== {1'b1, expBoot, expF7, expRelok}) begin
            errors++;
            $display("FAIL span_write: got %b expected %b", {nCPU_RST, BOOT, f7_q1, RELOK}, {1'b1, expBoot, expF7, expRelok});
        end
        nRESTART = 1'b1;
        step(4);
    endtask

    task automatic test_collision();
        int m;
        driveWrite(8'hF7, 8'h04, 4);
        applyWriteModel(8'hF7, 8'h04);
        nRESTART = 1'b0;
        step(DB_C - 1);
        A = 8'hF7; D = 8'h07; nIORQ = 1'b0; nWR = 1'b0;
        step(3);
        expBoot = 1'b1; expF7 = 1'b0; expRelok = 1'b0;
        checks++;
        if ({nCPU_RST, BOOT, f7_q1, RELOK} !== {1'b0, expBoot, expF7, expRelok}) begin
            errors++;
            $display("FAIL collision_edge: got %b expected %b", {nCPU_RST, BOOT, f7_q1, RELOK}, {1'b0, expBoot, expF7, expRelok});
        end
        step(3);
        nIORQ = 1'b1; nWR = 1'b1;
        nRESTART = 1'b1;
        m = 0;
        while (nCPU_RST !== 1'b1 && m < 100) begin
            step(1);
            m++;
        end
        step(2);
        checks++;
        if ({nCPU_RST, BOOT, f7_q1, RELOK} !== {1'b1, expBoot, expF7, expRelok}) begin
            errors++;
            $display("FAIL collision_after: got %b expected %b", {nCPU_RST, BOOT, f7_q1, RELOK}, {1'b1, expBoot, expF7, expRelok});
        end
    endtask

    initial begin
        step(1);
        test_reset();
        test_port_write();
        test_iah();
        test_restart_glitch();
        test_restart();
        test_collision();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/e800j_restart_ctrl.md
# e800j_restart_ctrl

Sequential control-register and restart sequencer for the Elwro 800 Junior memory map. It generates the BOOT, f7_q1 and RELOK mode signals consumed by the memory address decoder, and takes the decoder's nIAH strobe back as an input. It also holds the CPU in reset after power-up or a debounced RESTART key press, and services the I/O write that switches the map out of boot mode.

## Interface
Parameters:
- RST_CYCLES, 16: CPU reset hold length in CLK cycles, minimum 2.
- DEBOUNCE_CYCLES, 1024: number of cycles nRESTART must be stable low to trigger a restart, minimum 2.
- PORT_ADDR, 8'hF7: I/O port address of the control register.

Ports:
- CLK, input, 1: system clock. All bus inputs are asynchronous to it.
- nRESET, input, 1: asynchronous, active-low reset (power-on).
- A, input, [7:0]: CPU address bus, low byte.
- D, input, [7:0]: CPU data bus.
- nIORQ, input, 1: Z80 I/O request.
- nWR, input, 1: Z80 write strobe.
- nM1, input, 1: Z80 opcode-fetch cycle.
- nIAH, input, 1: decoder output; low marks a fetch region hit at 0x0000..0x03FF.
- nRESTART, input, 1: RESTART key, raw and bouncing.
- BOOT, output, 1: boot ROM mapped at 0x0000.
- f7_q1, output, 1: port F7 bit 0.
- RELOK, output, 1: relocated map enable.
- nCPU_RST, output, 1: CPU reset, active low.
- IAH_ACK, output, 1: one-cycle pulse when an IAH fetch has been serviced.

## Operation
- Input synchronisation:
  - nIORQ, nWR, nM1, nIAH and nRESTART each pass through a 2-flop synchroniser.
  - A and D are sampled unsynchronised, in the same cycle the synchronised write strobe is first seen.
- Port write:
  - wr_act = ~nIORQ_s & ~nWR_s & (A == PORT_ADDR).
  - A commit fires on the rising edge of wr_act, once per strobe; holding the strobe does not re-commit.
  - On commit: f7_q1 <= D[0]; RELOK <= D[1]; if D[2]=1 then BOOT <= 0.
  - BOOT is never set by a write.
  - Writes are ignored in HOLD.
- State machine, states HOLD, RUN, IAH_WAIT:
  - HOLD: nCPU_RST=0 and a counter runs from 0 to RST_CYCLES-1, then the state goes to RUN. Entered from reset, and from any state on restart_trig.
  - RUN: nCPU_RST=1. A synchronised nIAH=0 while nM1_s=0 moves the state to IAH_WAIT.
  - IAH_WAIT: waits for nM1_s=1. Then f7_q1 <= 0 and RELOK <= 0 (the next fetch maps ROM1), IAH_ACK pulses for 1 cycle, and the state returns to RUN.
- Restart:
  - The debounce counter counts up while nRESTART_s=0 and clears to 0 whenever nRESTART_s=1.
  - restart_trig fires once, when the count reaches DEBOUNCE_CYCLES-1. The counter then saturates and cannot re-fire until the key is released.
  - On restart_trig: BOOT <= 1, f7_q1 <= 0, RELOK <= 0, hold counter <= 0, state <= HOLD.
- Priority within one cycle: restart_trig > IAH_WAIT completion > port commit.
  - If a commit and IAH completion coincide, IAH clears f7_q1/RELOK, and the write's D[2] BOOT clear still applies.

## Timing
- Reset values (nRESET=0): state=HOLD, hold counter=0, BOOT=1, f7_q1=0, RELOK=0, nCPU_RST=0, IAH_ACK=0, debounce counter=0, synchroniser flops=1 (idle).
- After nRESET deasserts: nCPU_RST rises at the clock edge ending cycle RST_CYCLES, i.e. exactly RST_CYCLES edges later.
- Write latency: outputs update 3 edges after the strobe's first low sample (2 synchroniser edges plus 1 register edge).
- IAH_ACK and the f7_q1/RELOK clear appear 1 edge after the synchronised nM1 rises.
- Restart latency: nCPU_RST falls DEBOUNCE_CYCLES+2 edges after nRESTART goes stably low.
- A restart during HOLD restarts the hold count from 0.
- A write strobe spanning HOLD→RUN does not commit, because its rising edge occurred in HOLD.
- Bus inputs are stable for ≥3 CLK cycles per strobe (Z80 timing is guaranteed by the CLK ratio).

## Test plan
- Power-on: nRESET low then high → BOOT=1, f7_q1=0, RELOK=0; nCPU_RST=0 for exactly 16 edges, then 1.
- Port write in RUN: OUT (0xF7), 0x07 → f7_q1=1, RELOK=1, BOOT=0 after 3 edges. A strobe held 10 cycles commits once. A write with A=0xF6 changes nothing.
- IAH service: with f7_q1=RELOK=1, drive nM1=0 and nIAH=0, then nM1=1 → one IAH_ACK pulse, f7_q1=0, RELOK=0, BOOT unchanged.
- Restart debounce (DEBOUNCE_CYCLES=8 override): a glitch low for 5 cycles → no effect. Low for 20 cycles → exactly one restart: BOOT=1, nCPU_RST low for 16 cycles. A second restart requires release first.
- Write ignored in HOLD: OUT (0xF7), 0x04 issued during HOLD → BOOT stays 1.
- Collision: restart_trig in the same cycle as a port commit → restart values win (BOOT=1, f7_q1=0, RELOK=0).
